// File: rtl/mac_engine_pkg.sv
// mac_package: engine control/flag types and shared widths for mac_engine.
`default_nettype none

package mac_package;

  localparam int MAC_SHIFT_WIDTH = 5;
  localparam int MAC_LEN_WIDTH   = 16;

  typedef struct packed {
    logic                       clear;
    logic                       enable;
    logic                       start;
    logic                       simple_mul;
    logic [MAC_SHIFT_WIDTH-1:0] shift;
    logic [MAC_LEN_WIDTH-1:0]   len;
  } ctrl_engine_t;

  typedef struct packed {
    logic [MAC_LEN_WIDTH-1:0] cnt;
    logic                     acc_valid;
  } flags_engine_t;

endpackage

`default_nettype wire

// File: rtl/mac_engine_mulshift.sv
// mac_engine_mulshift: stage-1 signed multiply register and the stage-2 arithmetic shift.
`default_nettype none

module mac_engine_mulshift
  import mac_package::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       load_i,
  input  logic                       valid_i,
  input  logic [DATA_WIDTH-1:0]      a_i,
  input  logic [DATA_WIDTH-1:0]      b_i,
  input  logic [MAC_SHIFT_WIDTH-1:0] shift_i,
  output logic                       valid_o,
  output logic [2*DATA_WIDTH-1:0]    s_o
);

  logic [2*DATA_WIDTH-1:0] prod_q;
  logic                    valid_q;

  // load_i is the pipeline advance: when low the register holds (stall or freeze).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= valid_i;
      if (valid_i) begin
        prod_q <= $signed(a_i) * $signed(b_i);
      end
    end
  end

  assign valid_o = valid_q;
  assign s_o     = $unsigned($signed(prod_q) >>> shift_i);

endmodule

`default_nettype wire

// File: rtl/mac_engine.sv
// mac_engine: 2-stage signed MAC datapath (element-wise / scalar-accumulate) with stream backpressure.
// Optional: MAC_ENGINE_SATURATE_EN saturates the final d value to the signed DATA_WIDTH range.
`default_nettype none

module mac_engine
  import mac_package::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = MAC_LEN_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    test_mode_i,
  input  logic                    a_valid_i,
  output logic                    a_ready_o,
  input  logic [DATA_WIDTH-1:0]   a_data_i,
  input  logic                    b_valid_i,
  output logic                    b_ready_o,
  input  logic [DATA_WIDTH-1:0]   b_data_i,
  input  logic                    c_valid_i,
  output logic                    c_ready_o,
  input  logic [DATA_WIDTH-1:0]   c_data_i,
  output logic                    d_valid_o,
  input  logic                    d_ready_i,
  output logic [DATA_WIDTH-1:0]   d_data_o,
  output logic [DATA_WIDTH/8-1:0] d_strb_o,
  input  ctrl_engine_t            ctrl_i,
  output flags_engine_t           flags_o
);

  localparam int PW = 2 * DATA_WIDTH;

  logic                       unused_test_mode;
  logic [LEN_WIDTH-1:0]       len_q;
  logic [MAC_SHIFT_WIDTH-1:0] shift_q;
  logic                       simple_q;
  logic [LEN_WIDTH-1:0]       in_cnt_q;
  logic [LEN_WIDTH-1:0]       cnt_q;
  logic [PW-1:0]              acc_q;
  logic [DATA_WIDTH-1:0]      d_data_q;
  logic                       d_valid_q;

  logic                       flush;
  logic                       stall;
  logic                       s1_valid;
  logic                       s1_free;
  logic                       c_needed;
  logic                       retire;
  logic                       in_fire;
  logic                       last;
  logic                       emit;
  logic [PW-1:0]              shifted;
  logic [PW-1:0]              c_ext;
  logic [PW-1:0]              sum;
  logic [DATA_WIDTH-1:0]      result;

  assign unused_test_mode = test_mode_i;

  assign flush    = ctrl_i.clear | ctrl_i.start;
  assign stall    = d_valid_q & ~d_ready_i;
  // Element-wise needs c on every result; scalar only on the first one of the job.
  assign c_needed = simple_q | (cnt_q == '0);
  assign retire   = ctrl_i.enable & ~flush & s1_valid & ~stall & (~c_needed | c_valid_i);
  assign s1_free  = ~s1_valid | retire;
  assign in_fire  = ctrl_i.enable & ~flush & a_valid_i & b_valid_i & ~stall & s1_free
                  & (in_cnt_q < len_q);

  assign a_ready_o = in_fire;
  assign b_ready_o = in_fire;
  assign c_ready_o = retire & c_needed;

  mac_engine_mulshift #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mulshift (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush),
    .load_i  (ctrl_i.enable & s1_free),
    .valid_i (in_fire),
    .a_i     (a_data_i),
    .b_i     (b_data_i),
    .shift_i (shift_q),
    .valid_o (s1_valid),
    .s_o     (shifted)
  );

  assign c_ext = {{DATA_WIDTH{c_data_i[DATA_WIDTH-1]}}, c_data_i};
  assign sum   = (c_needed ? c_ext : acc_q) + shifted;
  assign last  = (cnt_q + LEN_WIDTH'(1)) == len_q;
  assign emit  = simple_q | last;

`ifdef MAC_ENGINE_SATURATE_EN
  // Overflow when the bits above the signed DATA_WIDTH range are not a pure sign extension.
  logic ovf;
  assign ovf    = ~((&sum[PW-1:DATA_WIDTH-1]) | ~(|sum[PW-1:DATA_WIDTH-1]));
  assign result = !ovf       ? sum[DATA_WIDTH-1:0] :
                  sum[PW-1]  ? {1'b1, {(DATA_WIDTH-1){1'b0}}} :
                               {1'b0, {(DATA_WIDTH-1){1'b1}}};
`else
  assign result = sum[DATA_WIDTH-1:0];
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q     <= '0;
      shift_q   <= '0;
      simple_q  <= 1'b0;
      in_cnt_q  <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      d_data_q  <= '0;
      d_valid_q <= 1'b0;
    end else if (flush) begin
      in_cnt_q  <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      d_data_q  <= '0;
      d_valid_q <= 1'b0;
      if (!ctrl_i.clear) begin
        len_q    <= ctrl_i.len;
        shift_q  <= ctrl_i.shift;
        simple_q <= ctrl_i.simple_mul;
      end
    end else begin
      if (in_fire) begin
        in_cnt_q <= in_cnt_q + LEN_WIDTH'(1);
      end
      // A pending d handshake completes even while the engine is frozen.
      if (d_valid_q && d_ready_i) begin
        d_valid_q <= 1'b0;
      end
      if (retire) begin
        if (cnt_q < len_q) begin
          cnt_q <= cnt_q + LEN_WIDTH'(1);
        end
        acc_q <= sum;
        if (emit) begin
          d_data_q  <= result;
          d_valid_q <= 1'b1;
        end
      end
    end
  end

  assign d_valid_o         = d_valid_q;
  assign d_data_o          = d_data_q;
  assign d_strb_o          = {(DATA_WIDTH/8){d_valid_q}};
  assign flags_o.cnt       = cnt_q;
  assign flags_o.acc_valid = d_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_engine.sv
// tb_mac_engine: table-driven directed vectors plus hand sequences for reset, len=0, abort and freeze.
`default_nettype none

module tb_mac_engine;
  import mac_package::*;

  typedef struct packed {
    logic             simple;
    logic [4:0]       shift;
    logic [15:0]      len;
    logic [7:0][31:0] a;
    logic [7:0][31:0] b;
    logic [7:0][31:0] c;
    logic [7:0][31:0] d;
    logic [3:0]       nd;
    logic [1:0]       mode;   // 0: ready high, 1: ready toggling, 2: enable freeze
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          test_mode = 1'b0;
  logic          a_valid, a_ready, b_valid, b_ready, c_valid, c_ready, d_valid, d_ready;
  logic [31:0]   a_data, b_data, c_data, d_data;
  logic [3:0]    d_strb;
  ctrl_engine_t  ctrl;
  flags_engine_t flags;

  int   checks = 0;
  int   fails  = 0;
  vec_t vecs[8];

  always #5 clk = ~clk;

  mac_engine #(.DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .test_mode_i (test_mode),
    .a_valid_i   (a_valid),
    .a_ready_o   (a_ready),
    .a_data_i    (a_data),
    .b_valid_i   (b_valid),
    .b_ready_o   (b_ready),
    .b_data_i    (b_data),
    .c_valid_i   (c_valid),
    .c_ready_o   (c_ready),
    .c_data_i    (c_data),
    .d_valid_o   (d_valid),
    .d_ready_i   (d_ready),
    .d_data_o    (d_data),
    .d_strb_o    (d_strb),
    .ctrl_i      (ctrl),
    .flags_o     (flags)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0][31:0] pk(input int e0 = 0, input int e1 = 0, input int e2 = 0,
                                          input int e3 = 0, input int e4 = 0, input int e5 = 0,
                                          input int e6 = 0, input int e7 = 0);
    logic [7:0][31:0] r;
    r[0] = e0; r[1] = e1; r[2] = e2; r[3] = e3;
    r[4] = e4; r[5] = e5; r[6] = e6; r[7] = e7;
    return r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_d_valid"}, d_valid, 0);
    check({tag, "_d_data"}, d_data, 0);
    check({tag, "_d_strb"}, d_strb, 0);
    check({tag, "_ab_ready"}, {a_ready, b_ready}, 0);
    check({tag, "_c_ready"}, c_ready, 0);
    check({tag, "_cnt"}, flags.cnt, 0);
    check({tag, "_acc_valid"}, flags.acc_valid, 0);
  endtask

  // Start a job and keep its inputs offered with d_ready low, so results pile up unconsumed.
  task automatic hold_job(input vec_t v, input int ncyc);
    @(posedge clk); #1;
    ctrl.start = 1'b1; ctrl.enable = 1'b1; ctrl.clear = 1'b0;
    ctrl.simple_mul = v.simple; ctrl.shift = v.shift; ctrl.len = v.len;
    a_valid = 1'b1; b_valid = 1'b1; c_valid = 1'b1;
    a_data = v.a[0]; b_data = v.b[0]; c_data = v.c[0]; d_ready = 1'b0;
    @(posedge clk); #1;
    ctrl.start = 1'b0;
    repeat (ncyc) @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int ai = 0, ci = 0, nout = 0, nc, post = 0, cnt_frz = 0, lat_idx;
    int acc_cyc[8];
    bit fa = 0, fc = 0, fd = 0, done = 0;
    nc      = v.simple ? int'(v.len) : 1;
    lat_idx = v.simple ? 0 : int'(v.len) - 1;
    @(posedge clk); #1;
    ctrl.start = 1'b1; ctrl.enable = 1'b1; ctrl.clear = 1'b0;
    ctrl.simple_mul = v.simple; ctrl.shift = v.shift; ctrl.len = v.len;
    a_valid = 1'b1; b_valid = 1'b1; a_data = v.a[0]; b_data = v.b[0];
    c_valid = 1'b0; d_ready = 1'b0;
    @(negedge clk);
    check({tag, "_start_no_accept"}, {a_ready, b_ready}, 0);
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      @(posedge clk); #1;
      ctrl.start = 1'b0;
      if (fa) ai++;
      if (fc) ci++;
      ctrl.enable = !(v.mode == 2 && cyc >= 2 && cyc <= 6);
      d_ready = (v.mode == 1) ? (cyc % 2 == 0) : 1'b1;
      a_valid = ai < int'(v.len);
      b_valid = a_valid;
      a_data  = (ai < 8) ? v.a[ai] : 32'h0;
      b_data  = (ai < 8) ? v.b[ai] : 32'h0;
      c_valid = ci < nc;
      c_data  = (ci < 8) ? v.c[ci] : 32'h0;
      @(negedge clk);
      fa = a_ready & b_ready;
      fc = c_ready;
      fd = d_valid & d_ready;
      if (fa && ai < 8) acc_cyc[ai] = cyc;
      check({tag, "_acc_valid_eq_d_valid"}, flags.acc_valid, d_valid);
      if (!ctrl.enable) begin
        check({tag, "_freeze_ready"}, {a_ready, b_ready, c_ready}, 0);
        if (cyc == 2) cnt_frz = int'(flags.cnt);
        else check({tag, "_freeze_cnt"}, flags.cnt, cnt_frz);
      end
      if (v.mode == 1 && d_valid && !d_ready)
        check({tag, "_stall_ready"}, {a_ready, b_ready}, 0);
      if (fd) begin
        if (nout < 8) check($sformatf("%s_d%0d", tag, nout), d_data, v.d[nout]);
        check({tag, "_strb"}, d_strb, 4'hF);
        if (nout == 0 && v.mode == 0) check({tag, "_latency"}, cyc - acc_cyc[lat_idx], 2);
        nout++;
      end
      if (nout >= int'(v.nd)) post++;
      if (post > 3) done = 1;
    end
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout: got %0d beats required %0d", tag, nout, v.nd);
    end
    check({tag, "_beats"}, nout, v.nd);
    check({tag, "_cnt_final"}, flags.cnt, v.len);
    check({tag, "_c_consumed"}, ci + (fc ? 1 : 0), nc);
    check({tag, "_idle_d_valid"}, d_valid, 0);
  endtask

  initial begin
    logic [31:0] sat_exp;
`ifdef MAC_ENGINE_SATURATE_EN
    sat_exp = 32'h7FFF_FFFF;
`else
    sat_exp = 32'h0000_0001;
`endif
    vecs[0] = '{1'b1, 5'd0, 16'd4, pk(1, 2, 3, 4), pk(5, 6, 7, 8), pk(1, 1, 1, 1),
                pk(6, 13, 22, 33), 4'd4, 2'd0};
    vecs[1] = '{1'b0, 5'd2, 16'd3, pk(4, 8, -12), pk(4, 4, 4), pk(10), pk(10), 4'd1, 2'd0};
    vecs[2] = '{1'b1, 5'd1, 16'd2, pk(-3, 7), pk(5, -2), pk(0, 100), pk(-8, 93), 4'd2, 2'd0};
    vecs[3] = '{1'b1, 5'd0, 16'd8, pk(1, 2, 3, 4, 5, 6, 7, 8), pk(3, 3, 3, 3, 3, 3, 3, 3),
                pk(0, 1, 2, 3, 4, 5, 6, 7), pk(3, 7, 11, 15, 19, 23, 27, 31), 4'd8, 2'd1};
    vecs[4] = '{1'b1, 5'd0, 16'd1, pk(32'h7FFF_FFFF), pk(32'h7FFF_FFFF), pk(0), pk(sat_exp),
                4'd1, 2'd0};
    vecs[5] = '{1'b0, 5'd0, 16'd1, pk(-1), pk(1), pk(-5), pk(-6), 4'd1, 2'd0};
    vecs[6] = '{1'b1, 5'd0, 16'd4, pk(2, 4, 6, 8), pk(1, 1, 1, 1), pk(0, 0, 0, 0),
                pk(2, 4, 6, 8), 4'd4, 2'd2};
    vecs[7] = '{1'b0, 5'd0, 16'd4, pk(1, 2, 3, 4), pk(1, 1, 1, 1), pk(100), pk(110), 4'd1, 2'd1};

    ctrl = '0;
    a_valid = 1'b1; b_valid = 1'b1; c_valid = 1'b1; d_ready = 1'b1;
    a_data = 32'd1; b_data = 32'd1; c_data = 32'd1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // len = 0: no handshakes, cnt and acc_valid stay 0
    @(posedge clk); #1;
    ctrl.start = 1'b1; ctrl.enable = 1'b1; ctrl.simple_mul = 1'b1; ctrl.len = '0;
    @(posedge clk); #1;
    ctrl.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("len0_ready", {a_ready, b_ready, c_ready}, 0);
      check("len0_flags", {flags.cnt, flags.acc_valid}, 0);
    end

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Abort: stale results from an interrupted job must never appear on d
    hold_job(vecs[3], 4);
    check("abort_pending_valid", d_valid, 1);
    run_vec(vecs[0], "abort_restart");

    // Reset while d is valid, then a fresh job
    hold_job(vecs[3], 4);
    check("rst_mid_pending_valid", d_valid, 1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_vec(vecs[2], "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
